// File: rtl/kernel_coeff_bank.sv
// Kernel coefficient store with random-access read, handshaked burst readout and a running tap sum.
// Optional macro KERNEL_SYM_EN mirrors each accepted write to index TAPS-1-i.
module kernel_coeff_bank #(
    parameter int COEF_W = 8,
    parameter int TAPS   = 7,
    parameter int ADDR_W = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [COEF_W-1:0]                wr_data,
    output logic                             wr_reject,
    input  logic [ADDR_W-1:0]                rd_addr,
    output logic [COEF_W-1:0]                rd_data,
    input  logic                             start,
    output logic                             busy,
    output logic                             tap_valid,
    input  logic                             tap_ready,
    output logic [COEF_W-1:0]                tap_data,
    output logic [ADDR_W-1:0]                tap_idx,
    output logic                             tap_last,
    output logic [COEF_W+$clog2(TAPS)-1:0]   coef_sum
);

    localparam int SUM_W = COEF_W + $clog2(TAPS);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   TAPS_X   = (ADDR_W+1)'(TAPS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TAPS - 1);

    function automatic logic [COEF_W-1:0] default_coef(input int i);
        case (i)
            0, 6:    return COEF_W'(1);
            1, 5:    return COEF_W'(10);
            2, 4:    return COEF_W'(50);
            3:       return COEF_W'(100);
            default: return '0;
        endcase
    endfunction

    function automatic logic [SUM_W-1:0] default_sum();
        int s;
        s = 0;
        for (int i = 0; i < TAPS; i++) s += int'(default_coef(i));
        return SUM_W'(s);
    endfunction

    localparam logic [SUM_W-1:0] RESET_SUM = default_sum();

    typedef enum logic {IDLE, STREAM} state_t;
    state_t state, state_next;

    logic [COEF_W-1:0] mem [DEPTH];
    logic              wr_in_range, rd_in_range, wr_ok, handshake;
    logic [SUM_W-1:0]  sum_next;

    assign wr_in_range = {1'b0, wr_addr} < TAPS_X;
    assign rd_in_range = {1'b0, rd_addr} < TAPS_X;
    assign wr_ok       = wr_en && wr_in_range && (state == IDLE);

    assign busy      = (state == STREAM);
    assign tap_valid = (state == STREAM);
    assign tap_last  = (state == STREAM) && (tap_idx == LAST_IDX);
    assign tap_data  = (state == STREAM) ? mem[tap_idx] : '0;
    assign handshake = tap_valid && tap_ready;

`ifdef KERNEL_SYM_EN
    logic [ADDR_W-1:0] mirror_addr;
    assign mirror_addr = LAST_IDX - wr_addr;
`endif

    // Incremental sum: drop the old tap value(s), add the new one(s); centre tap counted once.
    always_comb begin
        sum_next = coef_sum - SUM_W'(mem[wr_addr]) + SUM_W'(wr_data);
`ifdef KERNEL_SYM_EN
        if (mirror_addr != wr_addr)
            sum_next = sum_next - SUM_W'(mem[mirror_addr]) + SUM_W'(wr_data);
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = STREAM;
            STREAM:  if (handshake && tap_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data   <= '0;
            wr_reject <= 1'b0;
            tap_idx   <= '0;
            coef_sum  <= RESET_SUM;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= (i < TAPS) ? default_coef(i) : '0;
        end else begin
            // Read samples mem before this edge's write lands, so a colliding read sees the old value.
            rd_data   <= rd_in_range ? mem[rd_addr] : '0;
            wr_reject <= wr_en && !wr_ok;
            if (wr_ok) begin
                mem[wr_addr] <= wr_data;
`ifdef KERNEL_SYM_EN
                mem[mirror_addr] <= wr_data;
`endif
                coef_sum <= sum_next;
            end
            if (handshake)
                tap_idx <= tap_last ? '0 : tap_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_kernel_coeff_bank.sv
// Scoreboard bench for kernel_coeff_bank: reads, bursts with back-pressure, write rejection, reset abort.
module tb_kernel_coeff_bank;
    localparam int COEF_W = 8;
    localparam int TAPS   = 7;
    localparam int ADDR_W = 3;
    localparam int SUM_W  = COEF_W + $clog2(TAPS);

    logic              clk = 1'b0;
    logic              rst, wr_en, wr_reject, start, busy, tap_valid, tap_ready, tap_last;
    logic [ADDR_W-1:0] wr_addr, rd_addr, tap_idx;
    logic [COEF_W-1:0] wr_data, rd_data, tap_data;
    logic [SUM_W-1:0]  coef_sum;

    kernel_coeff_bank #(.COEF_W(COEF_W), .TAPS(TAPS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_reject(wr_reject), .rd_addr(rd_addr), .rd_data(rd_data), .start(start),
        .busy(busy), .tap_valid(tap_valid), .tap_ready(tap_ready), .tap_data(tap_data),
        .tap_idx(tap_idx), .tap_last(tap_last), .coef_sum(coef_sum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mdl [8];
    logic [31:0] sb_rd [$];
    logic [31:0] sb_tap [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_defaults();
        mdl = '{1, 10, 50, 100, 50, 10, 1, 0};
    endtask

    function automatic int model_sum();
        int s;
        s = 0;
        for (int i = 0; i < TAPS; i++) s += mdl[i];
        return s;
    endfunction

    task automatic model_write(input int a, input int d);
        if (a < TAPS) begin
            mdl[a] = d;
`ifdef KERNEL_SYM_EN
            mdl[TAPS-1-a] = d;
`endif
        end
    endtask

    task automatic push_taps();
        for (int i = 0; i < TAPS; i++) sb_tap.push_back(mdl[i]);
    endtask

    task automatic read_chk(input int a);
        rd_addr = ADDR_W'(a);
        sb_rd.push_back((a < TAPS) ? mdl[a] : 0);
        step();
        chk("rd_data", rd_data, sb_rd.pop_front());
    endtask

    task automatic write_cyc(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = COEF_W'(d);
        step();
        wr_en   = 1'b0;
    endtask

    // Drains a burst already in STREAM; optionally stalls stall_n cycles at stall_idx.
    task automatic burst(input int stall_idx, input int stall_n, input int exp_cycles);
        int cyc = 0;
        int stalls = 0;
        bit done = 0;
        for (int t = 0; t < 64 && !done; t++) begin
            tap_ready = 1'b1;
            if (tap_valid) begin
                cyc++;
                if (sb_tap.size() == 0) begin
                    chk("extra_tap", 1, 0);
                    done = 1;
                end else if (int'(tap_idx) == stall_idx && stalls < stall_n) begin
                    tap_ready = 1'b0;
                    stalls++;
                    chk("hold_data", tap_data, sb_tap[0]);
                end else begin
                    chk("tap_idx", tap_idx, TAPS - sb_tap.size());
                    chk("tap_data", tap_data, sb_tap.pop_front());
                    chk("tap_last", tap_last, sb_tap.size() == 0);
                    if (tap_last) done = 1;
                end
            end
            step();
        end
        tap_ready = 1'b0;
        chk("burst_done", done, 1);
        chk("burst_cycles", cyc, exp_cycles);
        chk("busy_after", busy, 0);
        chk("valid_after", tap_valid, 0);
        sb_tap.delete();
    endtask

    initial begin
        bit reached;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; start = 1'b0; tap_ready = 1'b0;
        load_defaults();
        step(); step();
        chk("rst_valid", tap_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_last", tap_last, 0);
        chk("rst_idx", tap_idx, 0);
        chk("rst_tapdata", tap_data, 0);
        chk("rst_reject", wr_reject, 0);
        chk("rst_rd", rd_data, 0);
        chk("rst_sum", coef_sum, 222);
        rst = 1'b0;

        for (int a = 0; a < 8; a++) read_chk(a);

        // Full-rate burst.
        start = 1'b1; push_taps(); step(); start = 1'b0;
        burst(-1, 0, 7);

        // Back-pressure at idx 3 for three cycles.
        start = 1'b1; push_taps(); step(); start = 1'b0;
        burst(3, 3, 10);

        // Write during STREAM is refused; start during STREAM ignored.
        start = 1'b1; push_taps(); step();
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'd20;
        step();
        wr_en = 1'b0; start = 1'b0;
        chk("rej_stream", wr_reject, 1);
        step();
        chk("rej_pulse_end", wr_reject, 0);
        burst(-1, 0, 7);
        read_chk(1);

        // Out-of-range write in IDLE.
        write_cyc(7, 99);
        chk("rej_range", wr_reject, 1);
        chk("sum_unchanged", coef_sum, model_sum());
        step();
        chk("rej_range_end", wr_reject, 0);

        // Accepted write updates the sum the next cycle.
        model_write(1, 20);
        write_cyc(1, 20);
        chk("acc_reject", wr_reject, 0);
        chk("sum_after_wr", coef_sum, model_sum());
        read_chk(1);
        read_chk(5);

        // Read/write collision returns the old value.
        rd_addr = 3'd1;
        sb_rd.push_back(mdl[1]);
        write_cyc(1, 33);
        chk("rd_collide", rd_data, sb_rd.pop_front());
        model_write(1, 33);
        read_chk(1);
        chk("sum_collide", coef_sum, model_sum());

        // Write and start in the same IDLE cycle; burst carries the new value.
        model_write(0, 7);
        push_taps();
        start = 1'b1;
        write_cyc(0, 7);
        start = 1'b0;
        burst(-1, 0, 7);

        // Reset mid-burst restores defaults.
        model_write(3, 0);
        write_cyc(3, 0);
        start = 1'b1; step(); start = 1'b0;
        tap_ready = 1'b1;
        reached = 0;
        for (int t = 0; t < 20 && !reached; t++) begin
            if (tap_idx == 3'd4) reached = 1;
            else step();
        end
        chk("reach_idx4", reached, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        tap_ready = 1'b0;
        chk("abort_valid", tap_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_idx", tap_idx, 0);
        load_defaults();
        chk("abort_sum", coef_sum, 222);
        read_chk(3);
        tap_ready = 1'b1;
        step();
        chk("no_restart", tap_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kernel_coeff_bank.md
KERNEL_COEFF_BANK -- requirements
Module: kernel_coeff_bank

Interface
REQ-001 Parameter COEF_W, default 8: coefficient width in bits.
REQ-002 Parameter TAPS, default 7, legal range 2..64: number of kernel taps.
REQ-003 Parameter ADDR_W, default 3: address width; the SHALL hold TAPS <= 2**ADDR_W.
REQ-004 clk  in  1: single clock; all logic SHALL be rising-edge triggered.
REQ-005 rst  in  1: reset, synchronous and active-high.
REQ-006 wr_en  in  1: coefficient write strobe.
REQ-007 wr_addr  in  ADDR_W: write tap index.
REQ-008 wr_data  in  COEF_W: write coefficient.
REQ-009 wr_reject  out  1: one-cycle pulse, write refused.
REQ-010 rd_addr  in  ADDR_W: random-access read index.
REQ-011 rd_data  out  COEF_W: registered read data.
REQ-012 start  in  1: request a burst of all taps.
REQ-013 busy  out  1: burst in progress.
REQ-014 tap_valid  out  1 / tap_ready  in  1: burst stream handshake.
REQ-015 tap_data  out  COEF_W / tap_idx  out  ADDR_W / tap_last  out  1: stream payload, index, final-tap flag.
REQ-016 coef_sum  out  COEF_W+$clog2(TAPS): sum of all stored taps, for normalisation.

Function
REQ-017 rd_data SHALL equal mem[rd_addr] one cycle after rd_addr is sampled; rd_addr >= TAPS SHALL return 0.
REQ-018 wr_en with wr_addr < TAPS in state IDLE SHALL commit wr_data at that clock edge.
REQ-019 wr_en with wr_addr >= TAPS, or in state STREAM, SHALL be ignored and SHALL pulse wr_reject high for exactly the next cycle.
REQ-020 A read and a write to the same address in the same cycle SHALL return the old value.
REQ-021 FSM SHALL have states IDLE and STREAM; IDLE->STREAM on start, STREAM->IDLE when tap_valid && tap_ready && tap_last.
REQ-022 start SHALL be ignored in STREAM.
REQ-023 In STREAM: tap_valid=1, busy=1, tap_data=mem[tap_idx], tap_last=(tap_idx==TAPS-1); in IDLE all four SHALL be 0 and tap_idx SHALL be 0.
REQ-024 tap_idx SHALL start at 0 and increment by 1 only on tap_valid && tap_ready; payload SHALL hold stable while tap_ready is low.
REQ-025 The first tap SHALL be presented the cycle after start is sampled; a write and a start in the same IDLE cycle SHALL both be accepted, and the burst SHALL carry the new value.
REQ-026 Back-to-back: with tap_ready held high, a TAPS-tap burst SHALL take exactly TAPS cycles, and busy SHALL drop the cycle after the last handshake.
REQ-027 coef_sum SHALL update the cycle after each accepted write, incrementally (sum - old + new), with no overflow, because its width covers TAPS*(2**COEF_W-1).

Reset
REQ-028 On rst: state=IDLE; rd_data=0; wr_reject=0; tap_valid=0; busy=0; tap_last=0; tap_idx=0; tap_data=0.
REQ-029 On rst: mem SHALL load the default table 1,10,50,100,50,10,1 into indices 0..6 (indices >= 7 load 0, indices >= TAPS are truncated), and coef_sum SHALL be set to the sum of the loaded table (222 for defaults).
REQ-030 rst asserted mid-burst SHALL abort the burst immediately, with no further handshakes, and SHALL restore the defaults of REQ-028/029.

Configuration
REQ-031 Macro KERNEL_SYM_EN defined: an accepted write to index i SHALL also write index TAPS-1-i in the same cycle; coef_sum SHALL account for both taps, counting the centre tap once when i==TAPS-1-i.
REQ-032 Macro KERNEL_SYM_EN undefined: a write SHALL affect only index i.

Verification
REQ-033 Reset, then read addresses 0..7 -> rd_data 1,10,50,100,50,10,1,0, each one cycle late; coef_sum=222.
REQ-034 start with tap_ready high -> 7 consecutive cycles carrying tap_data 1,10,50,100,50,10,1, tap_last only on idx 6, busy low on cycle 8.
REQ-035 start, then drop tap_ready for 3 cycles at idx 3 -> tap_data=100 held stable; burst completes in 10 cycles.
REQ-036 Write 20 to addr 1 during STREAM -> wr_reject pulse, mem unchanged; write to addr 7 in IDLE -> wr_reject pulse.
REQ-037 Write 20 to addr 1 in IDLE -> coef_sum=232 one cycle later; with KERNEL_SYM_EN, addr 5 also reads 20 and coef_sum=242.
REQ-038 rst at idx 4 of a burst after writing addr 3=0 -> tap_valid=0 next cycle, addr 3 reads 100, coef_sum=222.
